// File: rtl/loop_nest_pkg.sv
// Shared definitions for the nested loop address generator: FSM states,
// default widths and helpers for slicing flattened per-level fields.
package loop_nest_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int DEF_LEVELS = 3;
   localparam int DEF_CW     = 4;
   localparam int DEF_AW     = 32;

   // Low bit of field k in a flattened vector of w-bit fields.
   function automatic int fld_lo(input int k, input int w);
      return k * w;
   endfunction

endpackage

// File: rtl/loop_nest_level.sv
// One level of the loop nest: index counter plus the weight/input addresses
// captured at the start of the current iteration of this level.
module loop_nest_level
   import loop_nest_pkg::*;
#(
   parameter int CW = DEF_CW,
   parameter int AW = DEF_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          load,
   input  logic          carry_in,
   input  logic [CW-1:0] fin,
   input  logic [AW-1:0] wbase,
   input  logic [AW-1:0] ibase,
   input  logic [AW-1:0] wstride,
   input  logic [AW-1:0] istride,
   input  logic [AW-1:0] w_reload,
   input  logic [AW-1:0] i_reload,
   output logic [CW-1:0] idx,
   output logic          at_fin,
   output logic [AW-1:0] base_w,
   output logic [AW-1:0] base_i,
   output logic [AW-1:0] inc_w,
   output logic [AW-1:0] inc_i
);

   assign at_fin = (idx == fin);
   assign inc_w  = base_w + wstride;
   assign inc_i  = base_i + istride;

   // NOTE: registers update with <= so every level sees its neighbours' pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         idx    <= '0;
         base_w <= '0;
         base_i <= '0;
      end else if (load) begin
         idx    <= '0;
         base_w <= wbase;
         base_i <= ibase;
      end else if (carry_in) begin
         if (at_fin) begin
            // Wrapped: restart this level from the new base of the level that advanced.
            idx    <= '0;
            base_w <= w_reload;
            base_i <= i_reload;
         end else begin
            idx    <= idx + CW'(1);
            base_w <= inc_w;
            base_i <= inc_i;
         end
      end
   end

endmodule

// File: rtl/loop_nest_agen.sv
// Run-time configurable N-level loop nest emitting (idx, wa, ia) beats over valid/ready.
// Optional lvl_last output when LOOP_NEST_AGEN_LVL_FLAGS_EN is defined.
module loop_nest_agen
   import loop_nest_pkg::*;
#(
   parameter int LEVELS = DEF_LEVELS,
   parameter int CW     = DEF_CW,
   parameter int AW     = DEF_AW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [LEVELS*CW-1:0] cfg_fin,
   input  logic [AW-1:0]        cfg_wbase,
   input  logic [AW-1:0]        cfg_ibase,
   input  logic [LEVELS*AW-1:0] cfg_wstride,
   input  logic [LEVELS*AW-1:0] cfg_istride,
   output logic                 busy,
   output logic                 done,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [LEVELS*CW-1:0] idx,
   output logic [AW-1:0]        wa,
   output logic [AW-1:0]        ia,
`ifdef LOOP_NEST_AGEN_LVL_FLAGS_EN
   output logic [LEVELS-1:0]    lvl_last,
`endif
   output logic                 last
);

   state_t state, state_nxt;
   logic   load;
   logic   fire;
   logic   fire_last;

   logic [LEVELS*CW-1:0] fin_q;
   logic [LEVELS*AW-1:0] wstride_q;
   logic [LEVELS*AW-1:0] istride_q;

   logic [LEVELS-1:0] carry;
   logic [LEVELS-1:0] at_fin;
   logic [AW-1:0]     base_w [LEVELS];
   logic [AW-1:0]     base_i [LEVELS];
   logic [AW-1:0]     inc_w  [LEVELS];
   logic [AW-1:0]     inc_i  [LEVELS];
   logic [AW-1:0]     rel_w  [LEVELS];
   logic [AW-1:0]     rel_i  [LEVELS];

   assign out_valid = (state == RUN);
   assign busy      = out_valid;
   assign last      = out_valid & (&at_fin);
   assign fire      = out_valid & out_ready;
   assign fire_last = fire & last;
   assign wa        = base_w[0];
   assign ia        = base_i[0];

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path infers a latch.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         IDLE: if (start) begin
            load      = 1'b1;
            state_nxt = RUN;
         end
         RUN: if (fire_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fin_q     <= '0;
         wstride_q <= '0;
         istride_q <= '0;
      end else if (load) begin
         fin_q     <= cfg_fin;
         wstride_q <= cfg_wstride;
         istride_q <= cfg_istride;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) done <= 1'b0;
      else     done <= fire_last;
   end

   // Ripple carry from the innermost level: a level moves when all below it are at fin.
   always_comb begin
      logic c;
      c = fire;
      for (int k = 0; k < LEVELS; k++) begin
         carry[k] = c;
         c        = c & at_fin[k];
      end
   end

   // Reload value for level k is the new base of the lowest non-final level above it.
   always_comb begin
      logic [AW-1:0] cw, ci;
      cw = '0;
      ci = '0;
      for (int k = LEVELS - 1; k >= 0; k--) begin
         rel_w[k] = cw;
         rel_i[k] = ci;
         if (!at_fin[k]) begin
            cw = inc_w[k];
            ci = inc_i[k];
         end
      end
   end

   for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
      loop_nest_level #(
         .CW(CW),
         .AW(AW)
      ) u_lvl (
         .clk      (clk),
         .rst      (rst),
         .clear    (fire_last),
         .load     (load),
         .carry_in (carry[k]),
         .fin      (fin_q[fld_lo(k, CW) +: CW]),
         .wbase    (cfg_wbase),
         .ibase    (cfg_ibase),
         .wstride  (wstride_q[fld_lo(k, AW) +: AW]),
         .istride  (istride_q[fld_lo(k, AW) +: AW]),
         .w_reload (rel_w[k]),
         .i_reload (rel_i[k]),
         .idx      (idx[fld_lo(k, CW) +: CW]),
         .at_fin   (at_fin[k]),
         .base_w   (base_w[k]),
         .base_i   (base_i[k]),
         .inc_w    (inc_w[k]),
         .inc_i    (inc_i[k])
      );
   end

`ifdef LOOP_NEST_AGEN_LVL_FLAGS_EN
   always_comb begin
      logic acc;
      acc = busy;
      for (int k = 0; k < LEVELS; k++) begin
         acc         = acc & at_fin[k];
         lvl_last[k] = acc;
      end
   end
`endif

endmodule

// File: tb/tb_loop_nest_agen.sv
// Randomized scoreboard bench for loop_nest_agen: a nested-loop reference model
// queues expected beats; a negedge monitor checks transfers, stalls and done.
module tb_loop_nest_agen;
   localparam int LEVELS = 3;
   localparam int CW     = 4;
   localparam int AW     = 32;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 start = 1'b0;
   logic [LEVELS*CW-1:0] cfg_fin = '0;
   logic [AW-1:0]        cfg_wbase = '0;
   logic [AW-1:0]        cfg_ibase = '0;
   logic [LEVELS*AW-1:0] cfg_wstride = '0;
   logic [LEVELS*AW-1:0] cfg_istride = '0;
   logic                 busy, done, out_valid, last;
   logic                 out_ready = 1'b1;
   logic [LEVELS*CW-1:0] idx;
   logic [AW-1:0]        wa, ia;
`ifdef LOOP_NEST_AGEN_LVL_FLAGS_EN
   logic [LEVELS-1:0]    lvl_last;
`endif

   loop_nest_agen #(.LEVELS(LEVELS), .CW(CW), .AW(AW)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .cfg_fin     (cfg_fin),
      .cfg_wbase   (cfg_wbase),
      .cfg_ibase   (cfg_ibase),
      .cfg_wstride (cfg_wstride),
      .cfg_istride (cfg_istride),
      .busy        (busy),
      .done        (done),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .idx         (idx),
      .wa          (wa),
      .ia          (ia),
`ifdef LOOP_NEST_AGEN_LVL_FLAGS_EN
      .lvl_last    (lvl_last),
`endif
      .last        (last)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [LEVELS*CW-1:0] idx;
      logic [AW-1:0]        wa;
      logic [AW-1:0]        ia;
      logic                 last;
      logic [LEVELS-1:0]    ll;
   } beat_t;

   beat_t sb[$];
   int    n_tests = 0;
   int    n_fail = 0;
   int    beats_seen = 0;
   bit    rand_ready = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: plain nested loops, addresses as base + sum(index * stride).
   task automatic push_nest(input int f[LEVELS], input logic [AW-1:0] wb, input logic [AW-1:0] ib,
                            input logic [AW-1:0] ws[LEVELS], input logic [AW-1:0] is[LEVELS]);
      beat_t b;
      for (int i2 = 0; i2 <= f[2]; i2++)
         for (int i1 = 0; i1 <= f[1]; i1++)
            for (int i0 = 0; i0 <= f[0]; i0++) begin
               b.idx  = {CW'(i2), CW'(i1), CW'(i0)};
               b.wa   = wb + AW'(i0) * ws[0] + AW'(i1) * ws[1] + AW'(i2) * ws[2];
               b.ia   = ib + AW'(i0) * is[0] + AW'(i1) * is[1] + AW'(i2) * is[2];
               b.ll[0] = (i0 == f[0]);
               b.ll[1] = b.ll[0] && (i1 == f[1]);
               b.ll[2] = b.ll[1] && (i2 == f[2]);
               b.last = b.ll[2];
               sb.push_back(b);
            end
   endtask

   // Called at posedge+1; drives start for one cycle and checks first-beat latency.
   task automatic launch(input int f[LEVELS], input logic [AW-1:0] wb, input logic [AW-1:0] ib,
                         input logic [AW-1:0] ws[LEVELS], input logic [AW-1:0] is[LEVELS]);
      cfg_fin     = {CW'(f[2]), CW'(f[1]), CW'(f[0])};
      cfg_wbase   = wb;
      cfg_ibase   = ib;
      cfg_wstride = {ws[2], ws[1], ws[0]};
      cfg_istride = {is[2], is[1], is[0]};
      beats_seen  = 0;
      push_nest(f, wb, ib, ws, is);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("first_valid", {62'd0, out_valid, busy}, 64'd3);
   endtask

   task automatic wait_done();
      int cyc = 0;
      while (!done && cyc < 3000) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("done_seen", done, 1);
      check("sb_empty", sb.size(), 0);
   endtask

   task automatic pulse_start_busy();
      cfg_fin     = $urandom;
      cfg_wbase   = $urandom;
      cfg_ibase   = $urandom;
      cfg_wstride = {$urandom, $urandom, $urandom};
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   always @(posedge clk) begin
      #1;
      out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
   end

   // Monitor: transfer checks, stall stability and the done pulse.
   bit                   pend_done = 1'b0;
   bit                   stall = 1'b0;
   logic [LEVELS*CW-1:0] st_idx;
   logic [AW-1:0]        st_wa, st_ia;
   logic                 st_last;
   always @(negedge clk) begin
      if (rst) begin
         pend_done = 1'b0;
         stall     = 1'b0;
      end else begin
         if (pend_done || done) check("done_pulse", done, pend_done);
         pend_done = 1'b0;
         if (stall) begin
            check("stall_valid", out_valid, 1);
            check("stall_hold", {idx, wa, ia, last} == {st_idx, st_wa, st_ia, st_last}, 1);
         end
         stall = 1'b0;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL extra_beat: got idx=0x%0h wa=0x%0h expected no beat", idx, wa);
            end else begin
               beat_t e;
               e = sb.pop_front();
               check("beat_idx", idx, e.idx);
               check("beat_wa", wa, e.wa);
               check("beat_ia", ia, e.ia);
               check("beat_last", last, e.last);
`ifdef LOOP_NEST_AGEN_LVL_FLAGS_EN
               check("beat_lvl_last", lvl_last, e.ll);
`endif
            end
            beats_seen++;
            if (last) pend_done = 1'b1;
         end else if (out_valid) begin
            stall   = 1'b1;
            st_idx  = idx;
            st_wa   = wa;
            st_ia   = ia;
            st_last = last;
         end
      end
   end

   task automatic check_reset_state(input string tag);
      check({tag, "_valid"}, out_valid, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_last"}, last, 0);
      check({tag, "_idx"}, idx, 0);
      check({tag, "_wa"}, wa, 0);
      check({tag, "_ia"}, ia, 0);
`ifdef LOOP_NEST_AGEN_LVL_FLAGS_EN
      check({tag, "_lvl_last"}, lvl_last, 0);
`endif
   endtask

   initial begin
      int               f3[LEVELS] = '{2, 2, 2};
      int               f0[LEVELS] = '{0, 0, 0};
      int               fw[LEVELS] = '{3, 0, 0};
      int               fr[LEVELS];
      logic [AW-1:0]    ws3[LEVELS] = '{32'd1, 32'd3, 32'd9};
      logic [AW-1:0]    is3[LEVELS] = '{32'd1, 32'd10, 32'd100};
      logic [AW-1:0]    wsw[LEVELS] = '{32'd1, 32'd0, 32'd0};
      logic [AW-1:0]    wsr[LEVELS], isr[LEVELS];
      int               cyc;

      repeat (3) @(posedge clk);
      #1;
      check_reset_state("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // 3x3x3 nest with ready tied high, then back-to-back single-beat nest.
      launch(f3, 32'd0, 32'd0, ws3, is3);
      wait_done();
      launch(f0, 32'h100, 32'h200, ws3, is3);
      check("single_last", last, 1);
      wait_done();
      @(posedge clk); #1;
      check("idle_after", {out_valid, busy, done}, 0);

      // Same nest with random back-pressure and a start pulse while busy.
      rand_ready = 1'b1;
      launch(f3, 32'd0, 32'd0, ws3, is3);
      repeat (5) @(posedge clk);
      #1;
      pulse_start_busy();
      wait_done();

      // Address wrap past 2^AW.
      launch(fw, 32'hFFFF_FFFE, 32'd0, wsw, wsw);
      wait_done();

      // Reset after beat 10 aborts without done; a fresh start restarts at beat 1.
      rand_ready = 1'b0;
      @(posedge clk); #1;
      launch(f3, 32'd0, 32'd0, ws3, is3);
      cyc = 0;
      while (beats_seen < 10 && cyc < 500) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("beats_before_rst", beats_seen, 10);
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset_state("midrun_rst");
      rst = 1'b0;
      sb.delete();
      @(posedge clk); #1;
      check("no_done_after_rst", {done, out_valid}, 0);
      launch(f3, 32'd0, 32'd0, ws3, is3);
      wait_done();

      // Random configurations under random back-pressure.
      rand_ready = 1'b1;
      for (int n = 0; n < 5; n++) begin
         for (int k = 0; k < LEVELS; k++) begin
            fr[k]  = $urandom_range(0, 3);
            wsr[k] = $urandom;
            isr[k] = $urandom;
         end
         launch(fr, $urandom, $urandom, wsr, isr);
         wait_done();
      end

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
